// File: rtl/fifo_uart_tx.sv
// FIFO-to-UART bridge: pops bytes from a registered-output FIFO and sends each
// as an 8N1 frame (start 0, LSB-first data, stop 1) on a registered tx line.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(DATA_W + 1);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BaudW-1:0] BaudPen  = BaudW'(CLKS_PER_BIT - 2);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_W - 1);

  typedef enum logic [2:0] {StIdle, StPop, StLoad, StStart, StData, StStop} state_e;

  state_e            state;
  logic [BaudW-1:0]  baud_cnt;
  logic [BitW-1:0]   bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              baud_last;
  logic              start_ok;

  assign baud_last = (baud_cnt == BaudLast);
  assign start_ok  = tx_en && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
    end else begin
      fifo_rd_en <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        StIdle: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (start_ok) begin
            state      <= StPop;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        StPop: begin
          state <= StLoad;
        end
        StLoad: begin
          // FIFO output is valid now, one cycle after the pop strobe.
          shift_reg <= fifo_data;
          tx        <= 1'b0;
          baud_cnt  <= '0;
          state     <= StStart;
        end
        StStart: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shift_reg[0];
            state    <= StData;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        StData: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == BitLast) begin
              tx    <= 1'b1;
              state <= StStop;
            end else begin
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        StStop: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (start_ok) begin
              state      <= StPop;
              fifo_rd_en <= 1'b1;
            end else begin
              state <= StIdle;
              busy  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
            // Registered pulse lands on the final stop-bit cycle.
            if (baud_cnt == BaudPen) frame_done <= 1'b1;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural registered-output FIFO and
// a per-frame serial decoder that checks every bit period of tx.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       frame_done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [0:255];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int pops = 0;
  int bad_pops = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT(4),
    .DATA_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_en     (tx_en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  assign fifo_empty = (wr_cnt == rd_cnt);

  // FIFO model: registered data_out, valid the cycle after the pop edge.
  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1) begin
      pops <= pops + 1;
      if (wr_cnt == rd_cnt) begin
        bad_pops <= bad_pops + 1;
      end else begin
        fifo_data <= mem[rd_cnt[7:0]];
        rd_cnt    <= rd_cnt + 1;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wr_cnt[7:0]] = b;
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for the start bit, then samples 40 cycles of tx/frame_done.
  // drop_at/rst_at (frame cycle index, -1 = never) inject tx_en drop or reset.
  task automatic run_frame(input logic [7:0] b, input string tag, input int drop_at,
                           input int rst_at);
    int          waited;
    logic [39:0] txv;
    logic [39:0] fdv;
    logic [9:0]  fbits;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (tx !== 1'b0 && waited < 200);
    check({tag, "_latency"}, 40'(waited), 40'd3);
    if (tx !== 1'b0) return;
    txv = '0;
    fdv = '0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      txv[c] = tx;
      fdv[c] = frame_done;
      if (c == drop_at) tx_en = 1'b0;
      if (c == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        check({tag, "_rst_tx"}, 40'(tx), 40'd1);
        check({tag, "_rst_busy"}, 40'(busy), 40'd0);
        rst = 1'b0;
        return;
      end
    end
    fbits = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      check($sformatf("%s_bit%0d", tag, k), 40'(txv[4*k +: 4]), 40'({4{fbits[k]}}));
    end
    check({tag, "_frame_done"}, fdv, 40'h80_0000_0000);
  endtask

  initial begin
    logic [7:0] burst [0:15];
    int         p0;
    int         bad;

    // Reset with a byte already waiting.
    rst   = 1'b1;
    tx_en = 1'b1;
    push(8'hA5);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_tx", 40'(tx), 40'd1);
      check("reset_busy", 40'(busy), 40'd0);
      check("reset_rd_en", 40'(fifo_rd_en), 40'd0);
    end
    check("reset_no_pop", 40'(pops), 40'd0);
    rst = 1'b0;

    // Single byte 0xA5.
    run_frame(8'hA5, "a5", -1, -1);
    @(negedge clk);
    check("a5_busy_low", 40'(busy), 40'd0);
    check("a5_pops", 40'(pops), 40'd1);

    // tx_en dropped during data bit 3 with more bytes queued.
    tx_en = 1'b0;
    push(8'h3C);
    push(8'h77);
    push(8'h12);
    tx_en = 1'b1;
    p0 = pops;
    run_frame(8'h3C, "drop", 17, -1);
    @(negedge clk);
    check("drop_busy_low", 40'(busy), 40'd0);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad++;
    end
    check("drop_idle_quiet", 40'(bad), 40'd0);
    check("drop_pops", 40'(pops - p0), 40'd1);

    // Reset during data bit 5 of 0x77; 0x12 must follow cleanly.
    tx_en = 1'b1;
    run_frame(8'h77, "rst77", -1, 25);
    run_frame(8'h12, "after_rst", -1, -1);
    check("rst_pops", 40'(pops - p0), 40'd3);

    // Burst of 16 bytes, back-to-back.
    tx_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      burst[i] = 8'($urandom_range(0, 255));
      push(burst[i]);
    end
    p0 = pops;
    tx_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      run_frame(burst[i], $sformatf("burst%0d", i), -1, -1);
    end
    @(negedge clk);
    check("burst_busy_low", 40'(busy), 40'd0);
    check("burst_pops", 40'(pops - p0), 40'd16);
    check("no_pop_while_empty", 40'(bad_pops), 40'd0);

    // Empty FIFO with tx_en high.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_rd_en !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    check("empty_quiet", 40'(bad), 40'd0);
    check("empty_pops", 40'(pops - p0), 40'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
